sin_dds_gen: RTL and testbench
==============================

Name: sin_dds_gen

Overview:
- Parametrised successor to the fixed 20-point sine source used by the CVSD codec: a phase-accumulator DDS with a runtime frequency control word, amplitude scaling and four waveform modes.
- Drives the codec input and test stimulus with an unsigned offset-binary sample every clk_10k cycle.
- Uses a 65-entry quarter-wave table, giving 256 effective points per period.
- Two-stage output pipeline.

Parameters:
- PHASE_W, 16: accumulator width (≥8). f_out = fcw × f_clk / 2^PHASE_W.
- OUT_W, 8: output sample width (4..16), offset binary.
- FCW_RST, 3277: reset value of the FCW register (≈20 samples/period at PHASE_W=16).

Ports:
- clk_10k  in  1  sample clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  accumulator advance enable
- phase_rst  in  1  synchronous accumulator clear; priority over en
- fcw_in  in  PHASE_W  frequency control word
- fcw_load  in  1  latch fcw_in into FCW register
- amp_in  in  9  amplitude, 0..256; 256 = full scale; >256 clamps to 256
- mode  in  2  0 sine, 1 triangle, 2 square, 3 sawtooth
- sin_out  out  OUT_W  registered sample
- out_valid  out  1  sin_out reflects an enabled phase step
- zero_cross  out  1  one-cycle pulse aligned with the first sample after phase wrap

Behaviour:
- Interface: one clock, clk_10k; reset rst_n is asynchronous, active-low.
- Reset values: acc=0, fcw_r=FCW_RST, amp_r=256, stage-A s_a=0, sin_out=2^(OUT_W-1), out_valid=0, zero_cross=0, internal flags 0.
- FCW register: fcw_r<=fcw_in on fcw_load. On an edge with both fcw_load and en, acc uses the old fcw_r; the new value applies from the next edge (phase-continuous, no phase jump).
- Accumulator, in priority order:
  - phase_rst: acc<=0, wrap flag w0<=0.
  - Else en: acc<=acc+fcw_r mod 2^PHASE_W; w0<=carry out.
  - Else: acc holds, w0<=0.
- Stage A (every cycle, regardless of en): p = acc[PHASE_W-1:PHASE_W-8], q=p[7:6], i=p[5:0]. s_a <= signed 16-bit wave(p, mode):
  - Sine: Q[k]=round(32767·sin(π·k/128)), k=0..64. q0 → Q[i]; q1 → Q[64-i]; q2 → -Q[i]; q3 → -Q[64-i].
  - Triangle: same quadrant mirroring with T[k]=min(512·k, 32767).
  - Square: p[7]=0 → +32767, else -32767.
  - Sawtooth: (p-128)·256.
- Stage B (every cycle): m = (s_a × amp_r) >>> 8, then sin_out <= (m >>> (16-OUT_W)) + 2^(OUT_W-1).
  - Arithmetic shifts floor.
  - Result is in range by construction; no saturation logic is needed.
- Latency: an accumulator value appears on sin_out 2 edges later. With en=0, sin_out settles to the frozen phase's sample after 2 cycles.
- out_valid = en delayed 2 edges (v1<=en; out_valid<=v1). It ignores phase_rst.
- zero_cross: z1<=w0; zero_cross<=z1. Aligned with the sample computed from the wrapped acc.
- mode and amp_r changes take effect at the next stage-A/B edge. The phase is never disturbed.
- fcw_r=0 with en=1: constant output, no zero_cross.
- Reset mid-stream: all state returns to reset values immediately; the FCW load is lost.

Optional Feature:
- SIN_DDS_AMP_RAMP_EN defined: amp_r steps toward clamp(amp_in) by ±1 per clk_10k edge (click-free amplitude change; 0→256 takes 256 cycles). Holds when equal.
- Not defined: amp_r <= clamp(amp_in) every edge (one-cycle step).

Test Plan:
- Reset, OUT_W=8: sin_out=128, out_valid=0, zero_cross=0; fcw_r=3277 observable via period = 20 samples after en=1.
- fcw_load 16384, mode=0, amp_in=256, en=1 from edge 1: out_valid rises edge 2; sin_out = 128,255,128,0 repeating; zero_cross high with each 128 sample that follows a wrap (edge 6, 10, ...).
- Same FCW, mode=2, amp_in=128: sin_out alternates 191,191,64,64; mode=3 at amp 256: sin_out=0,64,128,192.
- phase_rst asserted with en=1 mid-period: acc=0 next edge; sin_out=128 two edges later; no zero_cross pulse from the reset.
- fcw_load 8192 on the same edge as en while acc=16384 (fcw_r=16384): next acc=32768, then 40960; output continuous with no discontinuity.
- With SIN_DDS_AMP_RAMP_EN: amp_in 256→0 step, square mode: |sin_out-128| decays by ≤1 LSB per 2 cycles, reaching 128 after 256 edges. Without the macro: sin_out=128 two edges after the step.

Source files
------------

// File: rtl/sin_dds_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sin_dds_gen
//
// Phase-accumulator direct digital synthesiser for the CVSD codec stimulus
// path. A PHASE_W-bit accumulator advances by a runtime frequency control word
// each enabled clk_10k edge. The top 8 phase bits address a 65-entry
// quarter-wave sine table, which gives 256 effective points per period. The
// waveform is then scaled by an amplitude word and emitted as an unsigned
// offset-binary sample. The output path has two pipeline stages:
//   stage A : phase -> signed 16-bit waveform value (s_a)
//   stage B : amplitude scaling and conversion to offset binary (sin_out)
//
// Parameters
//   PHASE_W  accumulator width (>= 8); f_out = fcw * f_clk / 2^PHASE_W
//   OUT_W    output sample width (4..16)
//   FCW_RST  frequency control word loaded at reset
//
// Ports
//   clk_10k     in   sample clock
//   rst_n       in   asynchronous active-low reset
//   en          in   accumulator advance enable
//   phase_rst   in   synchronous accumulator clear, wins over en
//   fcw_in      in   frequency control word (PHASE_W bits)
//   fcw_load    in   latch fcw_in into the FCW register
//   amp_in      in   amplitude 0..256 (256 = full scale, larger values clamp)
//   mode        in   0 sine, 1 triangle, 2 square, 3 sawtooth
//   sin_out     out  registered offset-binary sample (OUT_W bits)
//   out_valid   out  sin_out reflects an enabled phase step
//   zero_cross  out  one-cycle pulse on the first sample after a phase wrap
//
// Build option
//   SIN_DDS_AMP_RAMP_EN  when defined, the amplitude register slews toward
//                        the requested amplitude by one step per edge so
//                        amplitude changes are click-free; otherwise it
//                        follows the request on the next edge.
// -----------------------------------------------------------------------------
module sin_dds_gen #(
  parameter int          PHASE_W = 16,
  parameter int          OUT_W   = 8,
  parameter int unsigned FCW_RST = 3277
) (
  input  logic               clk_10k,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_rst,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_load,
  input  logic [8:0]         amp_in,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   sin_out,
  output logic               out_valid,
  output logic               zero_cross
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw_r;
  logic [PHASE_W:0]   sum;
  logic [8:0]         amp_r;
  logic [8:0]         amp_tgt;
  logic               w0;
  logic               z1;
  logic               v1;

  logic [7:0]         p;
  logic [1:0]         q;
  logic [5:0]         i;
  logic [6:0]         idx;
  logic [15:0]        sine_mag;
  logic [15:0]        tri_mag;
  logic [15:0]        mag;
  logic signed [15:0] wave;
  logic signed [15:0] s_a;
  logic signed [25:0] prod;
  logic [OUT_W-1:0]   sample;

  // Quarter-wave table: round(32767 * sin(pi * k / 128)), k = 0..64.
  function automatic logic [15:0] sine_q(input logic [6:0] k);
    logic [15:0] r;
    r = 16'd0;
    case (k)
      7'd0:  r = 16'd0;     7'd1:  r = 16'd804;   7'd2:  r = 16'd1608;  7'd3:  r = 16'd2410;
      7'd4:  r = 16'd3212;  7'd5:  r = 16'd4011;  7'd6:  r = 16'd4808;  7'd7:  r = 16'd5602;
      7'd8:  r = 16'd6393;  7'd9:  r = 16'd7179;  7'd10: r = 16'd7962;  7'd11: r = 16'd8739;
      7'd12: r = 16'd9512;  7'd13: r = 16'd10278; 7'd14: r = 16'd11039; 7'd15: r = 16'd11793;
      7'd16: r = 16'd12539; 7'd17: r = 16'd13279; 7'd18: r = 16'd14010; 7'd19: r = 16'd14732;
      7'd20: r = 16'd15446; 7'd21: r = 16'd16151; 7'd22: r = 16'd16846; 7'd23: r = 16'd17530;
      7'd24: r = 16'd18204; 7'd25: r = 16'd18868; 7'd26: r = 16'd19519; 7'd27: r = 16'd20159;
      7'd28: r = 16'd20787; 7'd29: r = 16'd21403; 7'd30: r = 16'd22005; 7'd31: r = 16'd22594;
      7'd32: r = 16'd23170; 7'd33: r = 16'd23731; 7'd34: r = 16'd24279; 7'd35: r = 16'd24811;
      7'd36: r = 16'd25329; 7'd37: r = 16'd25832; 7'd38: r = 16'd26319; 7'd39: r = 16'd26790;
      7'd40: r = 16'd27245; 7'd41: r = 16'd27683; 7'd42: r = 16'd28105; 7'd43: r = 16'd28510;
      7'd44: r = 16'd28898; 7'd45: r = 16'd29268; 7'd46: r = 16'd29621; 7'd47: r = 16'd29956;
      7'd48: r = 16'd30273; 7'd49: r = 16'd30571; 7'd50: r = 16'd30852; 7'd51: r = 16'd31113;
      7'd52: r = 16'd31356; 7'd53: r = 16'd31580; 7'd54: r = 16'd31785; 7'd55: r = 16'd31971;
      7'd56: r = 16'd32137; 7'd57: r = 16'd32285; 7'd58: r = 16'd32412; 7'd59: r = 16'd32521;
      7'd60: r = 16'd32609; 7'd61: r = 16'd32678; 7'd62: r = 16'd32728; 7'd63: r = 16'd32757;
      7'd64: r = 16'd32767;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  // Requested amplitude, clamped to full scale.
  assign amp_tgt = (amp_in > 9'd256) ? 9'd256 : amp_in;

  // The extra top bit of the sum is the wrap (carry) indication.
  assign sum = {1'b0, acc} + {1'b0, fcw_r};

  // A new FCW only affects the accumulator from the following edge, because
  // the adder always reads the registered value.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      fcw_r <= PHASE_W'(FCW_RST);
    end else if (fcw_load) begin
      fcw_r <= fcw_in;
    end
  end

  // Phase accumulator and wrap flag; phase_rst clears without signalling a wrap.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      w0  <= 1'b0;
    end else if (phase_rst) begin
      acc <= '0;
      w0  <= 1'b0;
    end else if (en) begin
      acc <= sum[PHASE_W-1:0];
      w0  <= sum[PHASE_W];
    end else begin
      w0  <= 1'b0;
    end
  end

`ifdef SIN_DDS_AMP_RAMP_EN
  // Slew the amplitude one step per edge toward the request.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      amp_r <= 9'd256;
    end else if (amp_r < amp_tgt) begin
      amp_r <= amp_r + 9'd1;
    end else if (amp_r > amp_tgt) begin
      amp_r <= amp_r - 9'd1;
    end
  end
`else
  // Amplitude follows the request on the next edge.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      amp_r <= 9'd256;
    end else begin
      amp_r <= amp_tgt;
    end
  end
`endif

  // Odd quadrants read the quarter table backwards (64 - i), which is why the
  // table holds 65 entries: the peak at k = 64 is reachable.
  assign p        = acc[PHASE_W-1 -: 8];
  assign q        = p[7:6];
  assign i        = p[5:0];
  assign idx      = q[0] ? (7'd64 - {1'b0, i}) : {1'b0, i};
  assign sine_mag = sine_q(idx);
  assign tri_mag  = (idx == 7'd64) ? 16'd32767 : {idx, 9'd0};
  assign mag      = (mode == 2'd1) ? tri_mag : sine_mag;

  // Stage A waveform selection. The second half of the period (q[1]) is the
  // negated first half for sine and triangle.
  always_comb begin
    wave = '0;
    case (mode)
      2'd0, 2'd1: wave = q[1] ? -$signed(mag) : $signed(mag);
      2'd2:       wave = p[7] ? -16'sd32767 : 16'sd32767;
      default:    wave = $signed({~p[7], p[6:0], 8'h00});
    endcase
  end

  // Both stage-B shifts floor, so they fold into one arithmetic shift of the
  // full product. Adding half scale to an in-range two's complement value is
  // just an MSB flip.
  assign prod   = s_a * $signed({1'b0, amp_r});
  assign sample = OUT_W'(prod >>> (24 - OUT_W)) ^ MID;

  // Output pipeline: stage A, stage B and the matching flag delays.
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      s_a        <= '0;
      sin_out    <= MID;
      v1         <= 1'b0;
      out_valid  <= 1'b0;
      z1         <= 1'b0;
      zero_cross <= 1'b0;
    end else begin
      s_a        <= wave;
      sin_out    <= sample;
      v1         <= en;
      out_valid  <= v1;
      z1         <= w0;
      zero_cross <= z1;
    end
  end

endmodule

// File: tb/tb_sin_dds_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sin_dds_gen
//
// Self-checking bench for sin_dds_gen at PHASE_W=16, OUT_W=8, FCW_RST=3277.
// A table of per-edge input/expected-output records drives the main waveform
// sequences; hand-written sequences cover reset, the reset FCW period, a
// mid-stream reset, the amplitude-128 square wave and the amplitude step
// (slewed when SIN_DDS_AMP_RAMP_EN is defined).
// -----------------------------------------------------------------------------
module tb_sin_dds_gen;

  localparam int PHASE_W = 16;
  localparam int OUT_W   = 8;

  logic               clk_10k = 1'b0;
  logic               rst_n;
  logic               en;
  logic               phase_rst;
  logic [PHASE_W-1:0] fcw_in;
  logic               fcw_load;
  logic [8:0]         amp_in;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   sin_out;
  logic               out_valid;
  logic               zero_cross;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic               en;
    logic               prst;
    logic               load;
    logic [PHASE_W-1:0] fcw;
    logic [1:0]         mode;
    int                 exp_sin;
    logic               exp_valid;
    logic               exp_zc;
  } vec_t;

  vec_t vecs[$];

  sin_dds_gen #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .FCW_RST(3277)) dut (
    .clk_10k   (clk_10k),
    .rst_n     (rst_n),
    .en        (en),
    .phase_rst (phase_rst),
    .fcw_in    (fcw_in),
    .fcw_load  (fcw_load),
    .amp_in    (amp_in),
    .mode      (mode),
    .sin_out   (sin_out),
    .out_valid (out_valid),
    .zero_cross(zero_cross)
  );

  always #5 clk_10k = ~clk_10k;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk_10k);
    #1;
  endtask

  task automatic apply_stimulus(input logic e, input logic pr, input logic ld,
                                input logic [PHASE_W-1:0] f, input logic [8:0] a,
                                input logic [1:0] m);
    en        = e;
    phase_rst = pr;
    fcw_load  = ld;
    fcw_in    = f;
    amp_in    = a;
    mode      = m;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic add_vec(input logic e, input logic pr, input logic ld,
                         input logic [PHASE_W-1:0] f, input logic [1:0] m,
                         input int s, input logic v, input logic z);
    vec_t r;
    r.en = e; r.prst = pr; r.load = ld; r.fcw = f; r.mode = m;
    r.exp_sin = s; r.exp_valid = v; r.exp_zc = z;
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 9'd256, 2'd0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // With the reset FCW of 3277 the accumulator wraps every 20 steps, so the
  // zero_cross pulses land on edges 22 and 42 after enabling.
  task automatic run_period_check(input string tag);
    int first_zc = -1;
    int second_zc = -1;
    int pulses = 0;
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 9'd256, 2'd0);
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 3) check_output({tag, "_sin_p12"}, sin_out, 165);
      if (n == 4) check_output({tag, "_sin_p25"}, sin_out, 201);
      if (zero_cross) begin
        pulses++;
        if (first_zc < 0) first_zc = n;
        else if (second_zc < 0) second_zc = n;
      end
    end
    check_output({tag, "_first_zc"}, first_zc, 22);
    check_output({tag, "_second_zc"}, second_zc, 42);
    check_output({tag, "_zc_pulses"}, pulses, 2);
  endtask

  initial begin
    int exp_sq[8];
    int prev;
    int bad;

    // Reset state.
    do_reset();
    check_output("rst_sin", sin_out, 128);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_zc", zero_cross, 0);

    // Reset FCW sets the period.
    run_period_check("por");

    // Load a new FCW, run, then reset mid-cycle: the load must be lost.
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'd16384, 9'd256, 2'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 9'd256, 2'd0);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_output("midrst_sin", sin_out, 128);
    check_output("midrst_valid", out_valid, 0);
    check_output("midrst_zc", zero_cross, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 9'd256, 2'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_period_check("postrst");

    // Table: en, phase_rst, fcw_load, fcw_in, mode, sin_out, out_valid, zero_cross.
    add_vec(0, 0, 1, 16384, 0, 128, 0, 0);
    add_vec(1, 0, 0, 0, 0, 128, 0, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0,   0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 1);
    add_vec(1, 0, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0,   0, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 1);
    add_vec(1, 0, 0, 0, 3, 255, 1, 0);
    add_vec(1, 0, 0, 0, 3, 128, 1, 0);
    add_vec(1, 0, 0, 0, 3, 192, 1, 0);
    add_vec(1, 0, 0, 0, 3,   0, 1, 1);
    add_vec(1, 0, 0, 0, 3,  64, 1, 0);
    add_vec(1, 0, 0, 0, 3, 128, 1, 0);
    add_vec(1, 0, 0, 0, 3, 192, 1, 0);
    add_vec(1, 0, 0, 0, 0,   0, 1, 1);
    add_vec(1, 1, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(0, 0, 0, 0, 0,   0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 128, 0, 1);
    add_vec(0, 0, 0, 0, 0, 128, 0, 0);
    add_vec(1, 0, 0, 0, 0, 128, 0, 0);
    add_vec(1, 0, 1, 8192, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 0);
    add_vec(1, 0, 0, 0, 0,  37, 1, 0);
    add_vec(1, 0, 0, 0, 0,   0, 1, 0);
    add_vec(1, 0, 0, 0, 0,  37, 1, 0);
    add_vec(1, 0, 0, 0, 0, 128, 1, 1);
    add_vec(1, 0, 0, 0, 0, 218, 1, 0);
    add_vec(1, 0, 0, 0, 0, 255, 1, 0);
    add_vec(1, 0, 0, 0, 0, 218, 1, 0);
    add_vec(1, 0, 0, 0, 1, 128, 1, 0);
    add_vec(1, 0, 0, 0, 1,  64, 1, 0);
    add_vec(1, 0, 0, 0, 1,   0, 1, 0);
    add_vec(1, 0, 0, 0, 1,  64, 1, 0);
    add_vec(1, 0, 0, 0, 1, 128, 1, 1);
    add_vec(1, 0, 0, 0, 1, 192, 1, 0);
    add_vec(1, 0, 0, 0, 1, 255, 1, 0);

    do_reset();
    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].en, vecs[k].prst, vecs[k].load, vecs[k].fcw, 9'd256, vecs[k].mode);
      tick();
      check_output($sformatf("vec%0d_sin", k), sin_out, vecs[k].exp_sin);
      check_output($sformatf("vec%0d_valid", k), out_valid, vecs[k].exp_valid);
      check_output($sformatf("vec%0d_zc", k), zero_cross, vecs[k].exp_zc);
    end

    // Square wave at half amplitude: settle amplitude with the phase frozen at 0.
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'd16384, 9'd128, 2'd2);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 9'd128, 2'd2);
    repeat (300) tick();
    check_output("sq_frozen_sin", sin_out, 191);
    check_output("sq_frozen_valid", out_valid, 0);
    exp_sq = '{191, 191, 191, 64, 64, 191, 191, 64};
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 9'd128, 2'd2);
    for (int n = 0; n < 8; n++) begin
      tick();
      check_output($sformatf("sq128_e%0d", n + 1), sin_out, exp_sq[n]);
    end

    // Amplitude step 256 -> 0 on a frozen positive square sample.
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 9'd256, 2'd2);
    repeat (300) tick();
    check_output("step_pre_sin", sin_out, 255);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 9'd0, 2'd2);
    tick();
    check_output("step_s0_sin", sin_out, 255);
`ifdef SIN_DDS_AMP_RAMP_EN
    bad  = 0;
    prev = int'(sin_out);
    for (int j = 1; j <= 260; j++) begin
      tick();
      if (int'(sin_out) > prev || prev - int'(sin_out) > 1) bad++;
      prev = int'(sin_out);
      if (j == 1)   check_output("ramp_j1_sin", sin_out, 255);
      if (j == 128) check_output("ramp_j128_sin", sin_out, 191);
      if (j == 256) check_output("ramp_j256_sin", sin_out, 128);
    end
    check_output("ramp_slew_violations", bad, 0);
`else
    bad  = 0;
    prev = 0;
    tick();
    check_output("step_s1_sin", sin_out, 128);
    tick();
    check_output("step_s2_sin", sin_out, 128);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
